// File: rtl/fighter_state_fsm_if.sv
// fighter_state_fsm_if: signal bundle between one fighter FSM and the arbiter/renderer.
// master drives controls and hit/block results; slave is the FSM.
interface fighter_state_fsm_if #(parameter int CNT_W = 6);
   logic frame_tick, facing, left, right, attack, got_hit, got_blocked, opp_diratk;
   logic [3:0] state;
   logic [CNT_W-1:0] frames_left;
   logic move_flag, basic_attack_flag, directional_attack_flag, hitbox_active, busy;
   modport master (
      output frame_tick, facing, left, right, attack, got_hit, got_blocked, opp_diratk,
      input  state, frames_left, move_flag, basic_attack_flag, directional_attack_flag, hitbox_active, busy
   );
   modport slave (
      input  frame_tick, facing, left, right, attack, got_hit, got_blocked, opp_diratk,
      output state, frames_left, move_flag, basic_attack_flag, directional_attack_flag, hitbox_active, busy
   );
endinterface

// File: rtl/fighter_state_fsm.sv
// fighter_state_fsm: per-player fighter state machine advancing on frame_tick.
// Define INPUT_BUFFER_EN to let late attack presses chain straight into the next attack.
module fighter_state_fsm #(
   parameter int CNT_W         = 6,
   parameter int ATK_START     = 5,
   parameter int ATK_ACTIVE    = 2,
   parameter int ATK_RECOV     = 16,
   parameter int DIR_START     = 4,
   parameter int DIR_ACTIVE    = 3,
   parameter int DIR_RECOV     = 15,
   parameter int HITSTUN_OFF   = 1,
   parameter int BLOCKSTUN_OFF = 3,
   parameter int BUF_WINDOW    = 4
) (
   input logic clk,
   input logic reset,
   fighter_state_fsm_if.slave bus
);
   function automatic bit bad_len(input int n);
      return n < 1 || n > (1 << CNT_W);
   endfunction
   if (bad_len(ATK_START) || bad_len(ATK_ACTIVE) || bad_len(ATK_RECOV) ||
       bad_len(DIR_START) || bad_len(DIR_ACTIVE) || bad_len(DIR_RECOV) ||
       bad_len(ATK_RECOV - HITSTUN_OFF) || bad_len(DIR_RECOV - HITSTUN_OFF) ||
       bad_len(ATK_RECOV - BLOCKSTUN_OFF) || bad_len(DIR_RECOV - BLOCKSTUN_OFF)) begin : g_cfg_err
      $error("fighter_state_fsm: phase or stun length outside 1..2**CNT_W");
   end
   // counter reload values are length-1 so each phase lasts exactly its length in ticks
   localparam logic [CNT_W-1:0] AS = CNT_W'(ATK_START - 1);
   localparam logic [CNT_W-1:0] AA = CNT_W'(ATK_ACTIVE - 1);
   localparam logic [CNT_W-1:0] AR = CNT_W'(ATK_RECOV - 1);
   localparam logic [CNT_W-1:0] DS = CNT_W'(DIR_START - 1);
   localparam logic [CNT_W-1:0] DA = CNT_W'(DIR_ACTIVE - 1);
   localparam logic [CNT_W-1:0] DR = CNT_W'(DIR_RECOV - 1);
   localparam logic [CNT_W-1:0] HA = CNT_W'(ATK_RECOV - HITSTUN_OFF - 1);
   localparam logic [CNT_W-1:0] HD = CNT_W'(DIR_RECOV - HITSTUN_OFF - 1);
   localparam logic [CNT_W-1:0] BA = CNT_W'(ATK_RECOV - BLOCKSTUN_OFF - 1);
   localparam logic [CNT_W-1:0] BD = CNT_W'(DIR_RECOV - BLOCKSTUN_OFF - 1);
   typedef enum logic [3:0] {
      IDLE, BACK, FWD, ATK_S, ATK_A, ATK_R, DIR_S, DIR_A, DIR_R, HITSTUN, BLOCKSTUN
   } state_t;
   state_t state_q, state_n, exit_s;
   logic [CNT_W-1:0] cnt_q, cnt_n, exit_c;
   logic fwd, back, dir, done;
`ifdef INPUT_BUFFER_EN
   localparam logic [CNT_W:0] BW = (CNT_W+1)'(BUF_WINDOW);
   logic buf_v, buf_dir, buf_v_n, buf_dir_n, win;
`endif
   always_comb begin
      fwd = bus.facing ? bus.right & ~bus.left : bus.left & ~bus.right;
      back = bus.facing ? bus.left & ~bus.right : bus.right & ~bus.left;
      dir = fwd ^ back;
      done = cnt_q == '0;
      state_n = state_q;
      cnt_n = cnt_q;
`ifdef INPUT_BUFFER_EN
      win = state_q inside {ATK_R, DIR_R, HITSTUN, BLOCKSTUN} && bus.attack && {1'b0, cnt_q} < BW;
      buf_v_n = buf_v | (bus.frame_tick & win);
      buf_dir_n = buf_v ? buf_dir : dir;
      exit_s = !buf_v_n ? IDLE : buf_dir_n ? DIR_S : ATK_S;
      exit_c = !buf_v_n ? '0 : buf_dir_n ? DS : AS;
`else
      exit_s = IDLE;
      exit_c = '0;
`endif
      if (bus.frame_tick) begin
         if (bus.got_hit | bus.got_blocked) begin
            state_n = bus.got_hit ? HITSTUN : BLOCKSTUN;
            cnt_n = bus.got_hit ? (bus.opp_diratk ? HD : HA) : (bus.opp_diratk ? BD : BA);
         end else if (state_q inside {IDLE, BACK, FWD}) begin
            state_n = bus.attack ? (dir ? DIR_S : ATK_S) : back ? BACK : fwd ? FWD : IDLE;
            cnt_n = bus.attack ? (dir ? DS : AS) : '0;
         end else if (!done && state_q <= BLOCKSTUN) begin
            cnt_n = cnt_q - 1'b1;
         end else begin
            case (state_q)
               ATK_S: begin state_n = ATK_A; cnt_n = AA; end
               ATK_A: begin state_n = ATK_R; cnt_n = AR; end
               DIR_S: begin state_n = DIR_A; cnt_n = DA; end
               DIR_A: begin state_n = DIR_R; cnt_n = DR; end
               ATK_R, DIR_R, HITSTUN, BLOCKSTUN: begin state_n = exit_s; cnt_n = exit_c; end
               default: begin state_n = IDLE; cnt_n = '0; end
            endcase
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
      end else begin
         state_q <= state_n;
         cnt_q <= cnt_n;
      end
   end
`ifdef INPUT_BUFFER_EN
   // buffer is consumed on the exit tick (counter at 0) and dropped on any hit/block
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_v <= 1'b0;
         buf_dir <= 1'b0;
      end else begin
         buf_v <= bus.frame_tick && (bus.got_hit || bus.got_blocked || done) ? 1'b0 : buf_v_n;
         buf_dir <= buf_dir_n;
      end
   end
`endif
   assign bus.state = state_q;
   assign bus.frames_left = cnt_q;
   assign bus.move_flag = state_q inside {BACK, FWD};
   assign bus.basic_attack_flag = state_q inside {ATK_S, ATK_A};
   assign bus.directional_attack_flag = state_q inside {DIR_S, DIR_A};
   assign bus.hitbox_active = state_q inside {ATK_A, DIR_A};
   assign bus.busy = state_q inside {[ATK_S:BLOCKSTUN]};
endmodule
